btb_param: RTL
==============

Name: btb_param

Overview:
- Parametrised successor to the fetch-stage branch target buffer.
- Fully associative BTB: ENTRIES entries, CTR_W-bit saturating direction counters.
- Return-address stack (RAS) of depth RAS_DEPTH:
  - circular; overflow overwrites the oldest entry;
  - its state is checkpointed with every prediction and restored on pipeline flush.
- Sits between IF (lookup, 1-cycle registered) and ID/EX (training, flush).

Parameters:
ENTRIES, 32, number of BTB entries; power of 2, 4..64
CTR_W, 3, direction counter width, 2..4
RAS_DEPTH, 8, RAS entries; power of 2, 2..32
IDX_W, $clog2(ENTRIES), entry index width (derived)
RP_W, $clog2(RAS_DEPTH), RAS pointer width (derived)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
fetch_en  in  1  lookup request
fetch_pc  in  32  lookup PC
pred_hit  out  1  valid BTB match for PC registered last cycle
pred_taken  out  1  counter MSB of matched entry
pred_target  out  32  predicted target, low 2 bits 0
pred_index  out  IDX_W  matched entry index
pred_ckpt  out  RP_W+RP_W+1  RAS checkpoint {top_ptr, count}
upd_en  in  1  training request
upd_op  in  2  0=DIR, 1=ADD, 2=DELETE, 3=TGT_FIX
upd_pc  in  32  branch PC
upd_index  in  IDX_W  entry for DIR/DELETE/TGT_FIX
upd_taken  in  1  resolved direction (DIR)
upd_target  in  32  resolved target (ADD/TGT_FIX)
upd_call  in  1  push upd_pc+4 onto RAS
upd_ret  in  1  pop RAS; on ADD, marks entry as return
flush_en  in  1  restore RAS from flush_ckpt
flush_ckpt  in  RP_W+RP_W+1  checkpoint to restore

Behaviour:
Reset (resetn=0 at a clk edge):
- all valid and ret bits cleared; RAS count=0, top_ptr=0; fetch_en_r=0.
- LFSR = 16'hACE1.
- RAS storage and entry data are not reset.

Outputs:
- All outputs are zero whenever pred_hit=0, including throughout reset. Exception: pred_ckpt always reflects current RAS state.

Lookup:
- fetch_pc is captured when fetch_en=1; fetch_en_r <= fetch_en.
- Next cycle, match[i] = fetch_en_r & valid[i] & (pc[i]==fetch_pc_r[31:2]) & !(ret[i] & count==0).
- Multiple matches: lowest index wins. Entries are not expected to duplicate; ADD guarantees this.
- pred_target = ret ? {ras[top_ptr-1], 2'b00} : {target, 2'b00}.
- Lookup sees state before any same-cycle update or flush.

Training (upd_en=1, one op per cycle):
- ADD:
  - Index selection: if upd_pc already matches a valid entry, that index is reused. Else the lowest invalid index. Else LFSR[IDX_W-1:0].
  - Writes pc, target, ret=upd_ret, valid=1.
  - Counter initialised to 1<<(CTR_W-1) (weakly taken).
- DELETE: valid[upd_index]=0, ret=0.
- TGT_FIX:
  - If upd_ret=1: no-op.
  - Otherwise: target=upd_target, counter=1<<(CTR_W-1), ret=0.
- DIR:
  - Counter increments if upd_taken, else decrements.
  - Saturates at all-ones / zero.

LFSR:
- Advances every cycle when not in reset.
- Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form.

RAS (upd_en=1, flush_en=0):
- Call only:
  - ras[top_ptr] <= upd_pc[31:2]+1; top_ptr++ (wraps mod RAS_DEPTH).
  - count = min(count+1, RAS_DEPTH). When full, the oldest entry is silently overwritten.
- Ret only: if count>0, top_ptr--, count--. Pop on empty is a no-op.
- Call and ret together: top entry is replaced in place (ras[top_ptr-1] <= upd_pc+4). Pointer and count unchanged; if count==0, behaves as a push.

Flush:
- flush_en=1 sets {top_ptr, count} <= flush_ckpt.
- Flush overrides any same-cycle RAS push/pop.
- Flush does not cancel same-cycle BTB table updates.
- RAS contents are not restored; only pointers.

Decomposition:
- btb_pkg:
  - upd_op encoding constants: OP_DIR, OP_ADD, OP_DELETE, OP_TGT_FIX;
  - LFSR seed and taps;
  - helper for counter init value.
- Sub-module btb_ras: circular stack with push/pop/replace, checkpoint output, restore input.
- Priority encoder (lowest-set index) as a function in btb_pkg.

Test Plan:
- ADD pc=0x1C000100 tgt=0x1C000200; next cycle fetch 0x1C000100 -> pred_hit=1, pred_taken=1, pred_target=0x1C000200.
- CTR_W=3: DIR not-taken ×5 on that entry -> counter 0, pred_taken=0; then taken ×9 -> counter saturates 7, pred_taken=1.
- Fill all 32 entries, then ADD new PC -> replaced index = LFSR[4:0] at that cycle. Re-ADD an existing PC -> same index, no duplicate.
- RAS_DEPTH=8: 9 calls from 0x1000, 0x1010, … 0x1080 (return addresses 0x1004, 0x1014, … 0x1084). Return entry hit then yields 0x1084, 0x1074 … down to 0x1014, 8 values in total; count stays 8 after 9 pushes.
- Capture pred_ckpt; do 2 calls; flush_en with that ckpt -> pred_ckpt equals captured value. Next ret lookup gives the pre-call top.
- Return entry with count==0 -> pred_hit=0. Assert resetn=0 mid-stream -> pred_hit=0 next cycle, all entries invalid.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared encodings and helpers for the parametrised branch target buffer.
// Holds the training op codes, the LFSR seed/taps and the small combinational helpers.
package btb_pkg;

    typedef enum logic [1:0] {
        OP_DIR     = 2'd0,
        OP_ADD     = 2'd1,
        OP_DELETE  = 2'd2,
        OP_TGT_FIX = 2'd3
    } upd_op_e;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form (taps on bits 0,2,3,5)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int ctr_init(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic logic [5:0] lowest_set(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/btb_ras.sv
// Circular return-address stack with push, pop and in-place replace.
// Pointer state is exported as a checkpoint and can be restored on flush.
module btb_ras
    import btb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int RP_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic [29:0]       push_data,
    input  logic              flush,
    input  logic [2*RP_W:0]   flush_ckpt,
    output logic [29:0]       top_data,
    output logic [2*RP_W:0]   ckpt,
    output logic              empty
);

    logic [29:0]     mem [DEPTH];
    logic [RP_W-1:0] top_ptr;
    logic [RP_W-1:0] top_m1;
    logic [RP_W:0]   count;
    logic            do_push;
    logic            do_replace;
    logic            do_pop;

    assign empty      = (count == '0);
    assign top_m1     = top_ptr - 1'b1;
    assign top_data   = mem[top_m1];
    assign ckpt       = {top_ptr, count};

    // call+ret on an empty stack degrades to a plain push
    assign do_push    = push && (!pop || empty);
    assign do_replace = push && pop && !empty;
    assign do_pop     = pop && !push && !empty;

    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            if (do_push) begin
                mem[top_ptr] <= push_data;
            end else if (do_replace) begin
                mem[top_m1] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (flush) begin
            top_ptr <= flush_ckpt[2*RP_W:RP_W+1];
            count   <= flush_ckpt[RP_W:0];
        end else if (do_push) begin
            top_ptr <= top_ptr + 1'b1;
            if (count != (RP_W+1)'(DEPTH)) count <= count + 1'b1;
        end else if (do_pop) begin
            top_ptr <= top_m1;
            count   <= count - 1'b1;
        end
    end

endmodule

// File: rtl/btb_param.sv
// Fully associative branch target buffer with saturating direction counters
// and a checkpointed return-address stack; lookup is registered by one cycle.
module btb_param
    import btb_pkg::*;
#(
    parameter int ENTRIES   = 32,
    parameter int CTR_W     = 3,
    parameter int RAS_DEPTH = 8,
    localparam int IDX_W = $clog2(ENTRIES),
    localparam int RP_W  = $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [IDX_W-1:0]  pred_index,
    output logic [2*RP_W:0]   pred_ckpt,
    input  logic              upd_en,
    input  logic [1:0]        upd_op,
    input  logic [31:0]       upd_pc,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_call,
    input  logic              upd_ret,
    input  logic              flush_en,
    input  logic [2*RP_W:0]   flush_ckpt
);

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] ret;
    logic [29:0]        tag [ENTRIES];
    logic [29:0]        tgt [ENTRIES];
    logic [CTR_W-1:0]   ctr [ENTRIES];

    logic               fetch_en_r;
    logic [29:0]        fetch_pc_r;
    logic [15:0]        lfsr;

    logic [ENTRIES-1:0] match;
    logic [ENTRIES-1:0] upd_match;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   add_idx;
    logic [CTR_W-1:0]   dir_next;
    logic [CTR_W-1:0]   dir_cur;

    logic [29:0]        ras_top;
    logic               ras_empty;
    logic               unused_bits;

    assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    btb_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk        (clk),
        .resetn     (resetn),
        .push       (upd_en && upd_call),
        .pop        (upd_en && upd_ret),
        .push_data  (upd_pc[31:2] + 30'd1),
        .flush      (flush_en),
        .flush_ckpt (flush_ckpt),
        .top_data   (ras_top),
        .ckpt       (pred_ckpt),
        .empty      (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_en_r <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else begin
            fetch_en_r <= fetch_en;
            lfsr       <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
        if (fetch_en) fetch_pc_r <= fetch_pc[31:2];
    end

    always_comb begin
        match     = '0;
        upd_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i]     = fetch_en_r && valid[i] && (tag[i] == fetch_pc_r)
                           && !(ret[i] && ras_empty);
            upd_match[i] = valid[i] && (tag[i] == upd_pc[31:2]);
        end
    end

    assign hit_idx = IDX_W'(lowest_set(64'(match)));

    // reuse an existing entry, else the first free one, else pseudo-random victim
    assign add_idx = (|upd_match) ? IDX_W'(lowest_set(64'(upd_match))) :
                     (~&valid)    ? IDX_W'(lowest_set(64'(~valid))) :
                                    lfsr[IDX_W-1:0];

    assign dir_cur = ctr[upd_index];

    always_comb begin
        dir_next = dir_cur;
        if (upd_taken && (dir_cur != '1)) dir_next = dir_cur + 1'b1;
        else if (!upd_taken && (dir_cur != '0)) dir_next = dir_cur - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= '0;
            ret   <= '0;
        end else if (upd_en) begin
            case (upd_op_e'(upd_op))
                OP_ADD: begin
                    valid[add_idx] <= 1'b1;
                    ret[add_idx]   <= upd_ret;
                end
                OP_DELETE: begin
                    valid[upd_index] <= 1'b0;
                    ret[upd_index]   <= 1'b0;
                end
                OP_TGT_FIX: begin
                    if (!upd_ret) ret[upd_index] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && upd_en) begin
            case (upd_op_e'(upd_op))
                OP_ADD: begin
                    tag[add_idx] <= upd_pc[31:2];
                    tgt[add_idx] <= upd_target[31:2];
                    ctr[add_idx] <= CTR_INIT;
                end
                OP_TGT_FIX: begin
                    if (!upd_ret) begin
                        tgt[upd_index] <= upd_target[31:2];
                        ctr[upd_index] <= CTR_INIT;
                    end
                end
                OP_DIR: ctr[upd_index] <= dir_next;
                default: ;
            endcase
        end
    end

    assign pred_hit    = resetn && (|match);
    assign pred_taken  = pred_hit && ctr[hit_idx][CTR_W-1];
    assign pred_target = !pred_hit     ? 32'd0 :
                         ret[hit_idx]  ? {ras_top, 2'b00} :
                                         {tgt[hit_idx], 2'b00};
    assign pred_index  = pred_hit ? hit_idx : '0;

endmodule
